// File: rtl/rast_pkg.sv
// Shared types and Q-format constants for the rasteriser barycentric path.
// Weights and areas are Q24.8; the reciprocal and normalized outputs set their own fractions.
package rast_pkg;

  localparam int unsigned W_FRAC     = 8;
  localparam int unsigned INV_FRAC_Q = 28;
  localparam int unsigned OUT_FRAC_Q = 16;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StMul,
    StOut
  } req_state_e;

  // Right shift that takes a weight*reciprocal product down to the output fraction.
  function automatic int unsigned norm_shift(input int unsigned inv_frac,
                                             input int unsigned out_frac);
    return W_FRAC + inv_frac - out_frac;
  endfunction

endpackage

// File: rtl/sat_shift_mul.sv
// Signed multiply, arithmetic right shift, then saturate into a signed OUT_WIDTH result.
// Purely combinational; the caller registers the result.
module sat_shift_mul #(
  parameter int unsigned A_WIDTH   = 32,
  parameter int unsigned B_WIDTH   = 32,
  parameter int unsigned OUT_WIDTH = 32,
  parameter int unsigned SHIFT     = 20
) (
  input  logic signed [A_WIDTH-1:0]   i_a,
  input  logic signed [B_WIDTH-1:0]   i_b,
  output logic signed [OUT_WIDTH-1:0] o_y
);

  localparam int unsigned P_WIDTH = A_WIDTH + B_WIDTH;

  logic signed [P_WIDTH-1:0] w_prod;
  logic signed [P_WIDTH-1:0] w_shr;
  logic signed [P_WIDTH-1:0] w_max;
  logic signed [P_WIDTH-1:0] w_min;

  assign w_prod = i_a * i_b;
  assign w_shr  = w_prod >>> SHIFT;

  // Output range limits, sign-extended to the full product width.
  assign w_max = {{(P_WIDTH - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  assign w_min = {{(P_WIDTH - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

  always_comb begin
    o_y = w_shr[OUT_WIDTH-1:0];
    if (w_shr > w_max) begin
      o_y = w_max[OUT_WIDTH-1:0];
    end else if (w_shr < w_min) begin
      o_y = w_min[OUT_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/tri_inv_requester.sv
// Normalizes a triangle's edge weights by its doubled area: requests 1/area from a shared
// reciprocal unit, then scales w0..w2 through one multiplier, one weight per cycle.
module tri_inv_requester
  import rast_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned INV_WIDTH  = 32,
  parameter int unsigned INV_FRAC   = INV_FRAC_Q,
  parameter int unsigned OUT_WIDTH  = 32,
  parameter int unsigned OUT_FRAC   = OUT_FRAC_Q
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tri_valid,
  output logic                         tri_ready,
  input  logic signed [DATA_WIDTH-1:0] tri_area,
  input  logic signed [DATA_WIDTH-1:0] tri_w0,
  input  logic signed [DATA_WIDTH-1:0] tri_w1,
  input  logic signed [DATA_WIDTH-1:0] tri_w2,
  input  logic                         inv_ready,
  output logic signed [DATA_WIDTH-1:0] inv_a,
  output logic                         inv_a_dv,
  input  logic signed [INV_WIDTH-1:0]  inv_result,
  input  logic                         inv_result_dv,
  output logic                         norm_valid,
  input  logic                         norm_ready,
  output logic signed [OUT_WIDTH-1:0]  norm_w0,
  output logic signed [OUT_WIDTH-1:0]  norm_w1,
  output logic signed [OUT_WIDTH-1:0]  norm_w2,
  output logic [15:0]                  cull_count
);

  localparam int unsigned SHIFT = norm_shift(INV_FRAC, OUT_FRAC);

  req_state_e r_state;

  logic signed [DATA_WIDTH-1:0] r_inv_a;
  logic signed [DATA_WIDTH-1:0] r_w0;
  logic signed [DATA_WIDTH-1:0] r_w1;
  logic signed [DATA_WIDTH-1:0] r_w2;
  logic signed [INV_WIDTH-1:0]  r_inv;
  logic [1:0]                   r_idx;
  logic signed [OUT_WIDTH-1:0]  r_p0;
  logic signed [OUT_WIDTH-1:0]  r_p1;
  logic signed [OUT_WIDTH-1:0]  r_norm_w0;
  logic signed [OUT_WIDTH-1:0]  r_norm_w1;
  logic signed [OUT_WIDTH-1:0]  r_norm_w2;
  logic                         r_norm_valid;
  logic [15:0]                  r_cull;

  logic signed [DATA_WIDTH-1:0] w_mul_a;
  logic signed [OUT_WIDTH-1:0]  w_prod;
  logic                         w_degenerate;

  always_comb begin
    w_mul_a = r_w0;
    case (r_idx)
      2'd1:    w_mul_a = r_w1;
      2'd2:    w_mul_a = r_w2;
      default: w_mul_a = r_w0;
    endcase
  end

  sat_shift_mul #(
    .A_WIDTH  (DATA_WIDTH),
    .B_WIDTH  (INV_WIDTH),
    .OUT_WIDTH(OUT_WIDTH),
    .SHIFT    (SHIFT)
  ) u_mul (
    .i_a(w_mul_a),
    .i_b(r_inv),
    .o_y(w_prod)
  );

  // Zero or negative area means degenerate or back-facing.
  assign w_degenerate = tri_area[DATA_WIDTH-1] || (tri_area == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_inv_a      <= '0;
      r_w0         <= '0;
      r_w1         <= '0;
      r_w2         <= '0;
      r_inv        <= '0;
      r_idx        <= 2'd0;
      r_p0         <= '0;
      r_p1         <= '0;
      r_norm_w0    <= '0;
      r_norm_w1    <= '0;
      r_norm_w2    <= '0;
      r_norm_valid <= 1'b0;
      r_cull       <= 16'd0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (tri_valid) begin
            r_w0 <= tri_w0;
            r_w1 <= tri_w1;
            r_w2 <= tri_w2;
            if (w_degenerate) begin
              r_cull <= r_cull + 16'd1;
            end else begin
              r_inv_a <= tri_area;
              r_state <= StIssue;
            end
          end
        end
        StIssue: begin
          if (inv_ready) begin
            r_state <= StWait;
          end
        end
        StWait: begin
          if (inv_result_dv) begin
            r_inv   <= inv_result;
            r_idx   <= 2'd0;
            r_state <= StMul;
          end
        end
        StMul: begin
          // Products are staged so norm_w* only change when the whole set is ready.
          case (r_idx)
            2'd0: begin
              r_p0  <= w_prod;
              r_idx <= 2'd1;
            end
            2'd1: begin
              r_p1  <= w_prod;
              r_idx <= 2'd2;
            end
            default: begin
              r_norm_w0    <= r_p0;
              r_norm_w1    <= r_p1;
              r_norm_w2    <= w_prod;
              r_norm_valid <= 1'b1;
              r_idx        <= 2'd0;
              r_state      <= StOut;
            end
          endcase
        end
        StOut: begin
          if (norm_ready) begin
            r_norm_valid <= 1'b0;
            r_state      <= StIdle;
          end
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign tri_ready  = (r_state == StIdle);
  assign inv_a_dv   = (r_state == StIssue) && inv_ready;
  assign inv_a      = r_inv_a;
  assign norm_valid = r_norm_valid;
  assign norm_w0    = r_norm_w0;
  assign norm_w1    = r_norm_w1;
  assign norm_w2    = r_norm_w2;
  assign cull_count = r_cull;

endmodule

// File: tb/tb_tri_inv_requester.sv
// Bench for tri_inv_requester: reciprocal-unit stub with fixed latency, expected weights
// queued at stimulus time and checked when norm_valid appears. Inputs change on negedge.
module tb_tri_inv_requester;

  typedef struct packed {
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        tri_valid;
  logic        tri_ready;
  logic [31:0] tri_area;
  logic [31:0] tri_w0;
  logic [31:0] tri_w1;
  logic [31:0] tri_w2;
  logic        inv_ready;
  logic [31:0] inv_a;
  logic        inv_a_dv;
  logic [31:0] inv_result;
  logic        inv_result_dv;
  logic        norm_valid;
  logic        norm_ready;
  logic [31:0] norm_w0;
  logic [31:0] norm_w1;
  logic [31:0] norm_w2;
  logic [15:0] cull_count;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reciprocal stub: answers with stub_result stub_lat cycles after the request cycle.
  int          stub_lat    = 10;
  int          stub_cnt    = 0;
  logic [31:0] stub_result = 32'h1000_0000;
  logic        stub_clr    = 1'b0;
  logic        force_dv    = 1'b0;
  int          req_cnt     = 0;
  logic [31:0] last_a      = 32'h0;

  assign inv_result    = stub_result;
  assign inv_result_dv = (stub_cnt == 1) || force_dv;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    #2;
    if (stub_clr) begin
      stub_cnt = 0;
    end else if (inv_a_dv && inv_ready) begin
      stub_cnt = stub_lat + 1;
      req_cnt++;
      last_a = inv_a;
    end else if (stub_cnt > 0) begin
      stub_cnt--;
    end
  end

  tri_inv_requester dut (
    .clk          (clk),
    .rst          (rst),
    .tri_valid    (tri_valid),
    .tri_ready    (tri_ready),
    .tri_area     (tri_area),
    .tri_w0       (tri_w0),
    .tri_w1       (tri_w1),
    .tri_w2       (tri_w2),
    .inv_ready    (inv_ready),
    .inv_a        (inv_a),
    .inv_a_dv     (inv_a_dv),
    .inv_result   (inv_result),
    .inv_result_dv(inv_result_dv),
    .norm_valid   (norm_valid),
    .norm_ready   (norm_ready),
    .norm_w0      (norm_w0),
    .norm_w1      (norm_w1),
    .norm_w2      (norm_w2),
    .cull_count   (cull_count)
  );

  task automatic drive_tri(input logic [31:0] a, input logic [31:0] w0,
                           input logic [31:0] w1, input logic [31:0] w2);
    tri_valid = 1'b1;
    tri_area  = a;
    tri_w0    = w0;
    tri_w1    = w1;
    tri_w2    = w2;
  endtask

  task automatic wait_norm(output int cycles, output bit ok);
    cycles = 0;
    ok     = 1'b0;
    while (cycles < 200) begin
      @(negedge clk);
      cycles++;
      if (norm_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_outputs(input string name);
    exp_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: norm_valid seen with no expected entry queued", name);
    end else begin
      e = exp_q.pop_front();
      if ({norm_w0, norm_w1, norm_w2} !== {e.w0, e.w1, e.w2}) begin
        n_bad++;
        $display("FAIL %s: got w0=%h w1=%h w2=%h want w0=%h w1=%h w2=%h",
                 name, norm_w0, norm_w1, norm_w2, e.w0, e.w1, e.w2);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({norm_valid, inv_a_dv, tri_ready} !== 3'b001) begin
      n_bad++;
      $display("FAIL reset_ctrl: got valid/dv/ready=%b want 001",
               {norm_valid, inv_a_dv, tri_ready});
    end
    n_vec++;
    if ({inv_a, norm_w0, norm_w1, norm_w2, cull_count} !== '0) begin
      n_bad++;
      $display("FAIL reset_data: got inv_a=%h w=%h/%h/%h cull=%0d want all zero",
               inv_a, norm_w0, norm_w1, norm_w2, cull_count);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int cycles;
    bit ok;
    int r0;
    r0 = req_cnt;
    drive_tri(32'd256, 32'd512, 32'd256, 32'hFFFF_FF00);
    exp_q.push_back('{w0: 32'h0002_0000, w1: 32'h0001_0000, w2: 32'hFFFF_0000});
    @(negedge clk);
    tri_valid = 1'b0;
    n_vec++;
    if (tri_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_busy: got tri_ready=%b want 0", tri_ready);
    end
    wait_norm(cycles, ok);
    n_vec++;
    if (!ok || (cycles + 1 != 15)) begin
      n_bad++;
      $display("FAIL basic_latency: got norm_valid at cycle %0d (seen=%0d) want 15",
               cycles + 1, ok);
    end
    check_outputs("basic_weights");
    n_vec++;
    if (last_a !== 32'd256 || req_cnt != r0 + 1) begin
      n_bad++;
      $display("FAIL basic_request: got inv_a=%h requests=%0d want 00000100 1",
               last_a, req_cnt - r0);
    end
    @(negedge clk);
    n_vec++;
    if ({norm_valid, tri_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL basic_release: got valid/ready=%b want 01", {norm_valid, tri_ready});
    end
  endtask

  task automatic test_cull();
    int  r0;
    bit  bad_rdy;
    bit  bad_out;
    r0      = req_cnt;
    bad_rdy = 1'b0;
    bad_out = 1'b0;
    drive_tri(32'd0, 32'd1, 32'd2, 32'd3);
    @(negedge clk);
    if (tri_ready !== 1'b1) bad_rdy = 1'b1;
    drive_tri(32'hFFFF_FF00, 32'd4, 32'd5, 32'd6);
    @(negedge clk);
    tri_valid = 1'b0;
    if (tri_ready !== 1'b1) bad_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (norm_valid !== 1'b0 || inv_a_dv !== 1'b0) bad_out = 1'b1;
      @(negedge clk);
    end
    n_vec++;
    if (cull_count !== 16'd2) begin
      n_bad++;
      $display("FAIL cull_count: got %0d want 2", cull_count);
    end
    n_vec++;
    if (bad_rdy) begin
      n_bad++;
      $display("FAIL cull_ready: got tri_ready=0 during culls want 1");
    end
    n_vec++;
    if (bad_out || req_cnt != r0) begin
      n_bad++;
      $display("FAIL cull_quiet: got requests=%0d stray_out=%0d want 0 0",
               req_cnt - r0, bad_out);
    end
  endtask

  task automatic test_stall();
    int cycles;
    bit ok;
    bit bad;
    int r0;
    r0  = req_cnt;
    bad = 1'b0;
    inv_ready = 1'b0;
    drive_tri(32'd512, 32'd256, 32'd512, 32'd768);
    exp_q.push_back('{w0: 32'h0001_0000, w1: 32'h0002_0000, w2: 32'h0003_0000});
    @(negedge clk);
    tri_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (inv_a_dv !== 1'b0 || tri_ready !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    n_vec++;
    if (bad) begin
      n_bad++;
      $display("FAIL stall_hold: got inv_a_dv or tri_ready high while stalled want 0");
    end
    inv_ready = 1'b1;
    #1;
    n_vec++;
    if (inv_a_dv !== 1'b1 || inv_a !== 32'd512) begin
      n_bad++;
      $display("FAIL stall_pulse: got dv=%b inv_a=%h want 1 00000200", inv_a_dv, inv_a);
    end
    @(negedge clk);
    n_vec++;
    if (inv_a_dv !== 1'b0 || req_cnt != r0 + 1) begin
      n_bad++;
      $display("FAIL stall_single: got dv=%b requests=%0d want 0 1", inv_a_dv, req_cnt - r0);
    end
    wait_norm(cycles, ok);
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL stall_done: got no norm_valid want norm_valid");
    end
    check_outputs("stall_weights");
    @(negedge clk);
  endtask

  task automatic test_saturate();
    int cycles;
    bit ok;
    stub_result = 32'h7FFF_FFFF;
    drive_tri(32'd256, 32'h7FFF_FF00, 32'h8000_0000, 32'd256);
    exp_q.push_back('{w0: 32'h7FFF_FFFF, w1: 32'h8000_0000, w2: 32'h0007_FFFF});
    @(negedge clk);
    tri_valid = 1'b0;
    wait_norm(cycles, ok);
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL sat_done: got no norm_valid want norm_valid");
    end
    check_outputs("sat_weights");
    @(negedge clk);
    stub_result = 32'h1000_0000;
  endtask

  task automatic test_back_to_back();
    int          cycles;
    bit          ok;
    bit          bad;
    int          r0;
    logic [95:0] snap;
    r0  = req_cnt;
    bad = 1'b0;
    norm_ready = 1'b0;
    drive_tri(32'd256, 32'd256, 32'd512, 32'hFFFF_FE00);
    exp_q.push_back('{w0: 32'h0001_0000, w1: 32'h0002_0000, w2: 32'hFFFE_0000});
    @(negedge clk);
    tri_valid = 1'b0;
    wait_norm(cycles, ok);
    snap = {norm_w0, norm_w1, norm_w2};
    drive_tri(32'd256, 32'd1024, 32'd0, 32'hFFFF_FC00);
    exp_q.push_back('{w0: 32'h0004_0000, w1: 32'h0000_0000, w2: 32'hFFFC_0000});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (norm_valid !== 1'b1 || tri_ready !== 1'b0 || {norm_w0, norm_w1, norm_w2} !== snap)
        bad = 1'b1;
    end
    n_vec++;
    if (!ok || bad || req_cnt != r0 + 1) begin
      n_bad++;
      $display("FAIL bp_hold: got seen=%0d unstable=%0d requests=%0d want 1 0 1",
               ok, bad, req_cnt - r0);
    end
    check_outputs("bp_first");
    norm_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({norm_valid, tri_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL bp_release: got valid/ready=%b want 01", {norm_valid, tri_ready});
    end
    @(negedge clk);
    tri_valid = 1'b0;
    n_vec++;
    if (tri_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_second_accept: got tri_ready=%b want 0", tri_ready);
    end
    wait_norm(cycles, ok);
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL bp_second_done: got no norm_valid want norm_valid");
    end
    check_outputs("bp_second");
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit bad;
    bad      = 1'b0;
    stub_lat = 50;
    drive_tri(32'd256, 32'd512, 32'd512, 32'd512);
    @(negedge clk);
    tri_valid = 1'b0;
    repeat (4) @(negedge clk);
    n_vec++;
    if ({tri_ready, inv_a_dv, norm_valid} !== 3'b000) begin
      n_bad++;
      $display("FAIL rmid_in_wait: got ready/dv/valid=%b want 000",
               {tri_ready, inv_a_dv, norm_valid});
    end
    rst      = 1'b1;
    stub_clr = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    stub_clr = 1'b0;
    repeat (2) @(negedge clk);
    force_dv = 1'b1;
    @(negedge clk);
    force_dv = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (norm_valid !== 1'b0 || inv_a_dv !== 1'b0 || tri_ready !== 1'b1) bad = 1'b1;
      @(negedge clk);
    end
    n_vec++;
    if (bad || cull_count !== 16'd0) begin
      n_bad++;
      $display("FAIL rmid_abandon: got activity=%0d cull=%0d want 0 0", bad, cull_count);
    end
    stub_lat = 10;
  endtask

  initial begin
    rst        = 1'b1;
    tri_valid  = 1'b0;
    tri_area   = '0;
    tri_w0     = '0;
    tri_w1     = '0;
    tri_w2     = '0;
    inv_ready  = 1'b1;
    norm_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_cull();
    test_stall();
    test_saturate();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/tri_inv_requester.md
TRI_INV_REQUESTER -- requirements
Module: tri_inv_requester

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of area and weight inputs, signed Q24.8.
REQ-002 Parameter INV_WIDTH, default 32: width of the reciprocal result, signed Q4.28.
REQ-003 Parameter INV_FRAC, default 28: fractional bits of the reciprocal result.
REQ-004 Parameter OUT_WIDTH, default 32: width of normalized outputs, signed Q16.16.
REQ-005 Parameter OUT_FRAC, default 16: fractional bits of normalized outputs.
REQ-006 clk  input  1  sole clock; all logic on posedge clk.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 tri_valid  input  1  upstream triangle valid.
REQ-009 tri_ready  output  1  block can accept a triangle.
REQ-010 tri_area  input  DATA_WIDTH  signed doubled triangle area, Q24.8.
REQ-011 tri_w0, tri_w1, tri_w2  input  DATA_WIDTH each  signed edge weights, Q24.8.
REQ-012 inv_ready  input  1  reciprocal unit idle and able to accept.
REQ-013 inv_a  output  DATA_WIDTH  value sent for inversion.
REQ-014 inv_a_dv  output  1  single-cycle request strobe.
REQ-015 inv_result  input  INV_WIDTH  reciprocal, Q4.28.
REQ-016 inv_result_dv  input  1  single-cycle result strobe.
REQ-017 norm_valid  output  1  normalized weights valid.
REQ-018 norm_ready  input  1  downstream accepts.
REQ-019 norm_w0, norm_w1, norm_w2  output  OUT_WIDTH each  normalized weights.
REQ-020 cull_count  output  16  triangles dropped as degenerate/back-facing, wraps at 65535->0.

Function
REQ-021 States SHALL be IDLE, ISSUE, WAIT, MUL, OUT.
REQ-022 IDLE: tri_ready=1; on tri_valid, capture area and w0..w2; area<=0 -> increment cull_count, stay IDLE; else -> ISSUE.
REQ-023 ISSUE: inv_a=captured area; inv_a_dv=1 only in a cycle where inv_ready=1, for exactly one cycle, then -> WAIT; while inv_ready=0, stay in ISSUE with inv_a_dv=0.
REQ-024 WAIT: on inv_result_dv capture inv_result -> MUL; no timeout; inv_result_dv in any other state SHALL be ignored.
REQ-025 MUL: one shared signed multiplier, one weight per cycle, w0, w1, w2 in order, 2-bit index counter; -> OUT after third product.
REQ-026 Product = w_i * inv (DATA_WIDTH+INV_WIDTH bits, 8+INV_FRAC fractional bits), arithmetic right shift by 8+INV_FRAC-OUT_FRAC, saturate to signed OUT_WIDTH range.
REQ-027 OUT: norm_valid=1, norm_w* stable until norm_ready=1; on handshake -> IDLE, norm_valid low next cycle.
REQ-028 tri_ready SHALL be 0 in every state except IDLE; at most one triangle in flight.
REQ-029 Latency tri accept -> norm_valid, with inv_ready=1 and result latency L: 1 (ISSUE) + L + 3 (MUL) + 1 cycles.
REQ-030 inv_a and norm_w* SHALL hold their last value outside their strobe/valid cycles.

Reset
REQ-031 On rst: state=IDLE, inv_a_dv=0, norm_valid=0, inv_a=0, norm_w*=0, cull_count=0, captured registers=0.
REQ-032 rst mid-operation SHALL abandon the triangle; a late inv_result_dv after reset SHALL be ignored (arrives in IDLE).

Structure
REQ-033 State enum and Q-format constants (8, INV_FRAC, OUT_FRAC) SHALL live in shared package rast_pkg.
REQ-034 Saturating shift-multiply SHALL be sub-module sat_shift_mul (combinational, parameterized widths/shift).

Verification
REQ-035 area=256, w0=512, w1=256, w2=-256; stub returns 1<<28 after 10 cycles -> norm_w = 0x20000, 0x10000, -0x10000; norm_valid at cycle 15 after accept.
REQ-036 area=0, then area=-256 -> no inv_a_dv, no norm_valid, cull_count=2, tri_ready stays 1.
REQ-037 inv_ready held 0 for 5 cycles in ISSUE -> inv_a_dv=0 throughout, single one-cycle pulse when inv_ready rises.
REQ-038 w0=0x7FFFFF00, inv=0x7FFFFFFF -> norm_w0=0x7FFFFFFF (saturated); w0=0x80000000 -> 0x80000000.
REQ-039 norm_ready low 4 cycles in OUT -> outputs stable, tri_ready=0; second tri_valid accepted only after handshake.
REQ-040 rst asserted in WAIT, stub pulses inv_result_dv 2 cycles later -> no norm_valid, state IDLE, cull_count=0.
